// File: rtl/dcnt16.sv
// dcnt16: programmable 16-bit down-counter/timer with prescaled count enable
//
// Optional feature macro: DCNT16_AUTO_RELOAD_EN
//   When it is defined, expiry reloads CNT from the reload register and the
//   block stays in RUN. When it is not defined, expiry is one-shot and the
//   reload register is not built.
//
// Parameters
//   PRE_DIV   CE pulses per decrement tick (1..65535)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   load      capture load_val into cnt (and the reload register); go IDLE
//   load_val  value captured on load
//   start     arm from IDLE (if cnt != 0) or resume from HALT
//   stop      pause a running count (RUN -> HALT)
//   ce        count enable, feeds the prescaler
//   cnt       current count, registered
//   busy      high in RUN or HALT, registered
//   done      one-cycle expiry pulse, registered
//   zero      combinational cnt == 0
module dcnt16 #(
   parameter int PRE_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        start,
   input  logic        stop,
   input  logic        ce,
   output logic [15:0] cnt,
   output logic        busy,
   output logic        done,
   output logic        zero
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   localparam logic [15:0] PRE_MAX = 16'(PRE_DIV - 1);
   state_t      state, state_nx;
   logic [15:0] cnt_nx, pre, pre_nx;
   logic        done_nx;
`ifdef DCNT16_AUTO_RELOAD_EN
   logic [15:0] rld;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rld <= '0;
      else if (load) rld <= load_val;
`endif
   // Commands are mutually exclusive by priority: LOAD > STOP > START > tick.
   // Each branch only fires when the command is meaningful in the current
   // state, so ignored commands fall through to the lower-priority ones.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pre_nx   = pre;
      done_nx  = 1'b0;
      if (load) begin
         cnt_nx   = load_val;
         pre_nx   = '0;
         state_nx = IDLE;
      end else if (stop && state == RUN) begin
         state_nx = HALT;
      end else if (start && state == IDLE && cnt != '0) begin
         state_nx = RUN;
         pre_nx   = '0;
      end else if (start && state == HALT) begin
         state_nx = RUN;
      end else if (state == RUN && ce) begin
         pre_nx = (pre == PRE_MAX) ? '0 : pre + 16'd1;
         if (pre == PRE_MAX) begin
            if (cnt == 16'd1) begin
               done_nx = 1'b1;
`ifdef DCNT16_AUTO_RELOAD_EN
               cnt_nx = rld;
`else
               cnt_nx   = '0;
               state_nx = IDLE;
`endif
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         pre   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pre   <= pre_nx;
         busy  <= (state_nx != IDLE);
         done  <= done_nx;
      end
   assign zero = (cnt == '0);
endmodule

// File: tb/tb_dcnt16.sv
// tb_dcnt16: scoreboard bench for dcnt16 with PRE_DIV = 1 and PRE_DIV = 4 instances
module tb_dcnt16;
`ifdef DCNT16_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst_n = 1'b0;
   logic        load = 0, start = 0, stop = 0, ce = 0;
   logic [15:0] load_val = '0;
   logic [15:0] cnt;
   logic        busy, done, zero;
   logic        load4 = 0, start4 = 0, stop4 = 0, ce4 = 0;
   logic [15:0] load_val4 = '0;
   logic [15:0] cnt4;
   logic        busy4, done4, zero4;
   dcnt16 #(.PRE_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
      .stop(stop), .ce(ce), .cnt(cnt), .busy(busy), .done(done), .zero(zero));
   dcnt16 #(.PRE_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .load(load4), .load_val(load_val4), .start(start4),
      .stop(stop4), .ce(ce4), .cnt(cnt4), .busy(busy4), .done(done4), .zero(zero4));
   typedef struct {
      string       tag;
      bit          sel;
      logic [15:0] cnt;
      logic        busy;
      logic        done;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask
   // Expected state after the next rising edge is queued, then the monitor
   // pops and compares it 1ns after that edge.
   task automatic step(input string tag, input bit sel, input logic [15:0] c,
                       input logic b, input logic d);
      q.push_back('{tag, sel, c, b, d});
      @(posedge clk);
      #2;
   endtask
   always begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({e.tag, ".cnt"},  e.sel ? cnt4 : cnt, e.cnt);
         chk({e.tag, ".busy"}, 16'(e.sel ? busy4 : busy), 16'(e.busy));
         chk({e.tag, ".done"}, 16'(e.sel ? done4 : done), 16'(e.done));
         chk({e.tag, ".zero"}, 16'(e.sel ? zero4 : zero), 16'(e.cnt == '0));
      end
   end
   int pulses;
   initial begin
      step("reset", 0, 16'd0, 0, 0);
      step("reset4", 1, 16'd0, 0, 0);
      rst_n = 1'b1;
      // basic count from 3, PRE_DIV = 1
      load_val = 16'd3; load = 1;
      step("t1_load", 0, 16'd3, 0, 0);
      load = 0; start = 1; ce = 1;
      step("t1_start", 0, 16'd3, 1, 0);
      start = 0;
      step("t1_c2", 0, 16'd2, 1, 0);
      step("t1_c1", 0, 16'd1, 1, 0);
      step("t1_exp", 0, AR ? 16'd3 : 16'd0, AR, 1);
      load_val = 16'd0; load = 1;
      step("t1_clr", 0, 16'd0, 0, 0);
      load = 0;
      // START with cnt == 0 is ignored
      start = 1;
      step("t1_start0", 0, 16'd0, 0, 0);
      start = 0;
      step("t1_idle0", 0, 16'd0, 0, 0);
      // STOP / HALT / resume
      load_val = 16'd10; load = 1;
      step("t3_load", 0, 16'd10, 0, 0);
      load = 0; start = 1;
      step("t3_start", 0, 16'd10, 1, 0);
      start = 0;
      for (int i = 1; i <= 3; i++) step($sformatf("t3_run%0d", i), 0, 16'(10 - i), 1, 0);
      stop = 1;
      step("t3_stop", 0, 16'd7, 1, 0);
      stop = 0;
      for (int i = 0; i < 5; i++) step($sformatf("t3_halt%0d", i), 0, 16'd7, 1, 0);
      start = 1;
      step("t3_resume", 0, 16'd7, 1, 0);
      start = 0;
      for (int i = 1; i <= 7; i++)
         step($sformatf("t3_tick%0d", i), 0,
              (i == 7) ? (AR ? 16'd10 : 16'd0) : 16'(7 - i), (i < 7) || AR, i == 7);
      // LOAD wins over an expiring tick
      load_val = 16'd2; load = 1;
      step("t4_load2", 0, 16'd2, 0, 0);
      load = 0; start = 1;
      step("t4_start", 0, 16'd2, 1, 0);
      start = 0;
      step("t4_c1", 0, 16'd1, 1, 0);
      load_val = 16'd5; load = 1;
      step("t4_loadexp", 0, 16'd5, 0, 0);
      load = 0;
      step("t4_after", 0, 16'd5, 0, 0);
      // PRE_DIV = 4, CE every other cycle
      load_val4 = 16'd2; load4 = 1;
      step("t2_load", 1, 16'd2, 0, 0);
      load4 = 0; start4 = 1;
      step("t2_start", 1, 16'd2, 1, 0);
      start4 = 0;
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         ce4 = (k % 2 == 0);
         if (ce4) pulses++;
         step($sformatf("t2_k%0d", k), 1,
              AR ? 16'(2 - (pulses % 8) / 4) : ((pulses >= 8) ? 16'd0 : 16'(2 - pulses / 4)),
              AR || pulses < 8, ce4 && pulses == 8);
      end
      ce4 = 0;
`ifdef DCNT16_AUTO_RELOAD_EN
      // auto-reload: DONE every 2 cycles, BUSY stays high
      load_val = 16'd2; load = 1;
      step("ar_load", 0, 16'd2, 0, 0);
      load = 0; start = 1;
      step("ar_start", 0, 16'd2, 1, 0);
      start = 0;
      for (int i = 0; i < 3; i++) begin
         step($sformatf("ar_c1_%0d", i), 0, 16'd1, 1, 0);
         step($sformatf("ar_c2_%0d", i), 0, 16'd2, 1, 1);
      end
      stop = 1;
      step("ar_stop", 0, 16'd1, 1, 0);
      stop = 0;
`endif
      // asynchronous reset mid-count
      load_val = 16'd10; load = 1;
      step("t6_load", 0, 16'd10, 0, 0);
      load = 0; start = 1;
      step("t6_start", 0, 16'd10, 1, 0);
      start = 0;
      step("t6_c9", 0, 16'd9, 1, 0);
      step("t6_c8", 0, 16'd8, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async.cnt", cnt, 16'd0);
      chk("t6_async.busy", 16'(busy), 16'd0);
      chk("t6_async.done", 16'(done), 16'd0);
      chk("t6_async.zero", 16'(zero), 16'd1);
      #1 rst_n = 1'b1;
      step("t6_rel0", 0, 16'd0, 0, 0);
      step("t6_rel1", 0, 16'd0, 0, 0);
      step("t6_rel2", 0, 16'd0, 0, 0);
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
